frame_object_scheduler: RTL

- Per-frame update controller for the game-object coordinates consumed by the pixel colour logic (player, projectile, three enemies).
- Movement/AI requesters post new positions at any time. The block round-robin grants one requester per cycle, but only inside the vertical-blanking window. Accepted values go into shadow registers.
- At window close, all shadow values are committed in a single cycle, so drawn coordinates never change mid-frame.

---
 rtl/frame_object_scheduler_pkg.sv | 33 +++
 rtl/frame_object_scheduler_rr_arbiter.sv | 27 ++
 rtl/frame_object_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/frame_object_scheduler_pkg.sv
// Shared game constants: object indices, coordinate sizing, scheduler state encoding.
// Also holds the round-robin pointer-advance helper used by the scheduler.
package frame_object_scheduler_pkg;

    localparam int NUM_OBJ  = 5;
    localparam int COORD_W  = 8;
    localparam int V_ACTIVE = 480;
    localparam int PTR_W    = $clog2(NUM_OBJ);

    localparam int OBJ_PLAYER = 0;
    localparam int OBJ_PROJ   = 1;
    localparam int OBJ_EN1    = 2;
    localparam int OBJ_EN2    = 3;
    localparam int OBJ_EN3    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_SERVICE = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    // Pointer to the slot just after the granted one, wrapping at NUM_OBJ.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_OBJ-1:0] onehot);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (onehot[i]) r = PTR_W'((i + 1) % NUM_OBJ);
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_object_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
// Zero latency; o_vld low when no request is set.
module frame_object_scheduler_rr_arbiter
    import frame_object_scheduler_pkg::*;
(
    input  logic [NUM_OBJ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_OBJ-1:0] o_gnt,
    output logic               o_vld
);

    int w_idx;

    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NUM_OBJ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_OBJ;
            if (!o_vld && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_vld        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_object_scheduler.sv
// Gathers object position updates into shadow registers during vertical blanking and
// commits them all in one cycle; grant is registered (one cycle after arbitration).
module frame_object_scheduler
    import frame_object_scheduler_pkg::*;
#(
    parameter int SVC_MAX = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [9:0]                 i_next_x,
    input  logic [9:0]                 i_next_y,
    input  logic [NUM_OBJ-1:0]         i_req,
    input  logic [NUM_OBJ*COORD_W-1:0] i_req_x,
    input  logic [NUM_OBJ*COORD_W-1:0] i_req_y,
    output logic [NUM_OBJ-1:0]         o_grant,
    output logic [NUM_OBJ*COORD_W-1:0] o_obj_x,
    output logic [NUM_OBJ*COORD_W-1:0] o_obj_y,
    output logic [NUM_OBJ-1:0]         o_obj_valid,
    output logic                       o_frame_tick,
    output logic                       o_busy
);

    localparam int CNT_W = $clog2(SVC_MAX + 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PTR_W-1:0]           r_rr_ptr;
    logic [NUM_OBJ-1:0]         r_served;
    logic [NUM_OBJ-1:0]         r_dirty;
    logic [NUM_OBJ-1:0]         r_grant;
    logic [NUM_OBJ-1:0]         r_obj_valid;
    logic                       r_frame_tick;
    logic [CNT_W-1:0]           r_svc_cnt;
    logic [COORD_W-1:0]         r_sh_x [NUM_OBJ];
    logic [COORD_W-1:0]         r_sh_y [NUM_OBJ];
    logic [NUM_OBJ*COORD_W-1:0] r_obj_x;
    logic [NUM_OBJ*COORD_W-1:0] r_obj_y;

    logic [NUM_OBJ-1:0]         w_elig;
    logic [NUM_OBJ-1:0]         w_gnt;
    logic                       w_gnt_vld;
    logic                       w_win_open;
    logic                       w_svc_done;

    assign w_elig     = i_req & ~r_served;
    assign w_win_open = (i_next_y == 10'(V_ACTIVE)) && (i_next_x == 10'd0);
    // Leave service once nothing is left after this grant, on budget exhaustion, or on frame wrap.
    assign w_svc_done = ((w_elig & ~w_gnt) == '0) ||
                        (r_svc_cnt == CNT_W'(SVC_MAX - 1)) ||
                        (i_next_y == 10'd0);

    frame_object_scheduler_rr_arbiter u_arb (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_vld (w_gnt_vld)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_state_nxt = ST_ACTIVE;
            ST_ACTIVE:  if (w_win_open) w_state_nxt = ST_SERVICE;
            ST_SERVICE: if (w_svc_done) w_state_nxt = ST_COMMIT;
            ST_COMMIT:  w_state_nxt = ST_ACTIVE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (!i_start) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr_ptr     <= PTR_W'(OBJ_PLAYER);
            r_served     <= '0;
            r_dirty      <= '0;
            r_grant      <= '0;
            r_obj_valid  <= '0;
            r_frame_tick <= 1'b0;
            r_svc_cnt    <= '0;
            r_obj_x      <= '0;
            r_obj_y      <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_sh_x[i] <= '0;
                r_sh_y[i] <= '0;
            end
        end else if (!i_start) begin
            // Clear abandons any partially gathered window; committed coordinates hold.
            r_served     <= '0;
            r_dirty      <= '0;
            r_grant      <= '0;
            r_obj_valid  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_grant      <= '0;
            r_frame_tick <= 1'b0;
            case (r_state)
                ST_ACTIVE: begin
                    if (w_win_open) begin
                        r_served  <= '0;
                        r_svc_cnt <= '0;
                    end
                end
                ST_SERVICE: begin
                    if (r_svc_cnt != {CNT_W{1'b1}}) r_svc_cnt <= r_svc_cnt + 1'b1;
                    if (w_gnt_vld) begin
                        r_grant  <= w_gnt;
                        r_served <= r_served | w_gnt;
                        r_dirty  <= r_dirty | w_gnt;
                        r_rr_ptr <= ptr_after(w_gnt);
                        for (int i = 0; i < NUM_OBJ; i++) begin
                            if (w_gnt[i]) begin
                                r_sh_x[i] <= i_req_x[i*COORD_W +: COORD_W];
                                r_sh_y[i] <= i_req_y[i*COORD_W +: COORD_W];
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < NUM_OBJ; i++) begin
                        if (r_dirty[i]) begin
                            r_obj_x[i*COORD_W +: COORD_W] <= r_sh_x[i];
                            r_obj_y[i*COORD_W +: COORD_W] <= r_sh_y[i];
                        end
                    end
                    r_obj_valid  <= r_obj_valid | r_dirty;
                    r_dirty      <= '0;
                    r_frame_tick <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_grant      = r_grant;
    assign o_obj_x      = r_obj_x;
    assign o_obj_y      = r_obj_y;
    assign o_obj_valid  = r_obj_valid;
    assign o_frame_tick = r_frame_tick;
    assign o_busy       = (r_state == ST_SERVICE) || (r_state == ST_COMMIT);

endmodule
